// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory controller: access-size codes,
// FSM state encoding, byte-enable generation and load extension.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Low address bits below the access size are ignored here; the size code 11 acts as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lane;
            SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: align_wdata = {4{wdata[7:0]}};
            SZ_HALF: align_wdata = {2{wdata[15:0]}};
            default: align_wdata = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = {{24{~uns & b[7]}}, b};
            SZ_HALF: load_extend = {{16{~uns & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between the load/store logic (master) and the data memory (slave).
// Handshake: a request transfers on a rising edge where ReqValid && ReqReady; RspValid is a one-cycle pulse.
interface data_mem_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        RspValid;
    logic [31:0] ReadData;
    logic        RspErr;
    logic        InitDone;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
        input  ReqReady, RspValid, ReadData, RspErr, InitDone
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
        output ReqReady, RspValid, ReadData, RspErr, InitDone
    );
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 32 single-port RAM with per-byte write enables and a registered read,
// written in the plain style that maps onto block RAM.
module data_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // The read register only moves on a pure read, so it keeps the last loaded word.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            if (i_we == 4'b0000) begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: init sweep, request FSM, range/alignment checks and lane logic.
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 1,
    parameter int INIT_MODE = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    data_mem_if.slave   bus,
    output state_t      o_dbg_state
);

    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic [1:0]    r_wait;
    logic          r_write;
    logic [1:0]    r_size;
    logic [1:0]    r_lane;
    logic          r_uns;
    logic          r_err;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic          r_init_done;
    logic [31:0]   r_rd_hold;

    logic          w_accept;
    logic          w_range_err;
    logic          w_misalign;
    logic          w_req_err;
    logic          w_ram_en;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;
    logic [31:0]   w_rsp_data;

    assign w_range_err = |bus.Address[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = (bus.ReqSize == SZ_BYTE) ? 1'b0 :
                        (bus.ReqSize == SZ_HALF) ? bus.Address[0] :
                                                   (bus.Address[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = w_range_err | w_misalign;
    assign w_accept  = Reset & (r_state == ST_IDLE) & r_req_ready & bus.ReqValid;

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 4'b0000;
        w_ram_addr  = bus.Address[AW+1:2];
        w_ram_wdata = align_wdata(bus.ReqSize, bus.WriteData);
        if (Reset && r_state == ST_INIT) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 4'b1111;
            w_ram_addr  = r_cnt;
            w_ram_wdata = (INIT_MODE != 0) ? 32'(r_cnt) : 32'd0;
        end else if (w_accept) begin
            w_ram_en = 1'b1;
            if (bus.ReqWrite && !w_req_err) begin
                w_ram_we = byte_en(bus.ReqSize, bus.Address[1:0]);
            end
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (Clock),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ReadData follows the RAM only during RESP and is frozen into r_rd_hold on the way out.
    assign w_rsp_data = (r_write || r_err) ? 32'd0 : load_extend(w_ram_rdata, r_size, r_lane, r_uns);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_wait      <= 2'd0;
            r_write     <= 1'b0;
            r_size      <= SZ_WORD;
            r_lane      <= 2'd0;
            r_uns       <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_init_done <= 1'b0;
            r_rd_hold   <= 32'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= bus.ReqWrite;
                        r_size      <= bus.ReqSize;
                        r_lane      <= bus.Address[1:0];
                        r_uns       <= bus.ReqUnsigned;
                        r_err       <= w_req_err;
                        r_req_ready <= 1'b0;
                        if (bus.ReqWrite || READ_LAT == 1) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_req_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_wait  <= 2'(READ_LAT - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait == 2'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_rd_hold   <= w_rsp_data;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.ReqReady = r_req_ready;
    assign bus.RspValid = r_rsp_valid;
    assign bus.RspErr   = r_rsp_err;
    assign bus.InitDone = r_init_done;
    assign bus.ReadData = (r_state == ST_RESP) ? w_rsp_data : r_rd_hold;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset/init timing, mid-operation reset,
// and randomized traffic checked against a byte-array reference model.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int RL    = 3;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     n_vec;
    int     n_miss;

    data_mem_if bus ();

    data_mem_ctrl #(
        .DEPTH     (DEPTH),
        .READ_LAT  (RL),
        .INIT_MODE (1)
    ) dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [7:0] mem_b [0:DEPTH*4-1];

    function automatic int acc_bytes(input logic [1:0] s);
        return (s == SZ_BYTE) ? 1 : (s == SZ_HALF) ? 2 : 4;
    endfunction

    task automatic model_init();
        for (int w = 0; w < DEPTH; w++) begin
            for (int i = 0; i < 4; i++) mem_b[w*4 + i] = 8'((w >> (8*i)) & 255);
        end
    endtask

    task automatic model_access(input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] ed, output logic ee);
        int          n;
        logic [31:0] base;
        logic [31:0] v;
        n    = acc_bytes(s);
        base = a & ~(32'(n) - 32'd1);
        ee   = ((a >> 2) >= 32'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if (base != a) ee = 1'b1;
`endif
        ed = 32'd0;
        if (!ee) begin
            if (w) begin
                for (int i = 0; i < n; i++) mem_b[int'(base) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[int'(base) + i];
                if (!u && v[8*n-1]) begin
                    for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
                end
                ed = v;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic reset_and_init();
        int n;
        bus.ReqValid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.ReqReady), 32'd0);
        check("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
        check("rst_read_data", bus.ReadData, 32'd0);
        check("rst_rsp_err", 32'(bus.RspErr), 32'd0);
        check("rst_init_done", 32'(bus.InitDone), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (!bus.InitDone && n < DEPTH + 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("init_cycles", 32'(n), 32'(DEPTH));
        model_init();
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in its idle state.
    task automatic run_req(input string name, input logic w, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] ed, input logic ee);
        int          n;
        int          lat;
        int          exp_lat;
        n = 0;
        while (!bus.ReqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ReqReady) begin
            check({name, "_ready_timeout"}, 32'(bus.ReqReady), 32'd1);
            return;
        end
        bus.ReqWrite    = w;
        bus.ReqSize     = s;
        bus.ReqUnsigned = u;
        bus.Address     = a;
        bus.WriteData   = wd;
        bus.ReqValid    = 1'b1;
        @(posedge clk);
        #1;
        bus.ReqValid    = 1'b0;
        bus.ReqWrite    = 1'($urandom);
        bus.ReqSize     = 2'($urandom);
        bus.ReqUnsigned = 1'($urandom);
        bus.Address     = $urandom;
        bus.WriteData   = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.RspValid && lat < 8);
        exp_lat = w ? 1 : RL;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (!bus.RspValid) return;
        check({name, "_data"}, bus.ReadData, ed);
        check({name, "_err"}, 32'(bus.RspErr), 32'(ee));
        check({name, "_busy"}, 32'(bus.ReqReady), 32'd0);
        @(negedge clk);
        check({name, "_pulse"}, 32'(bus.RspValid), 32'd0);
        check({name, "_hold"}, bus.ReadData, ed);
        check({name, "_ready_after"}, 32'(bus.ReqReady), 32'd1);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vt [17];

    initial begin
        logic [31:0] ed;
        logic        ee;
        logic [31:0] a;
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] wd;
        int          seen;
        int          rdy;

        vt[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h00000004, 1'b0};
        vt[1]  = '{1'b1, SZ_WORD, 1'b0, 32'h40,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[2]  = '{1'b0, SZ_WORD, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[3]  = '{1'b0, SZ_BYTE, 1'b0, 32'h43,  32'h0,        32'hFFFFFFDE, 1'b0};
        vt[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h43,  32'h0,        32'h000000DE, 1'b0};
        vt[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h40,  32'h0,        32'hFFFFBEEF, 1'b0};
        vt[6]  = '{1'b1, SZ_BYTE, 1'b0, 32'h41,  32'hAAAAAA55, 32'h0,        1'b0};
        vt[7]  = '{1'b0, SZ_WORD, 1'b0, 32'h40,  32'h0,        32'hDEAD55EF, 1'b0};
        vt[8]  = '{1'b0, SZ_WORD, 1'b0, 32'(DEPTH*4), 32'h0,   32'h0,        1'b1};
        vt[9]  = '{1'b1, SZ_WORD, 1'b0, 32'(DEPTH*4), 32'h12345678, 32'h0,   1'b1};
        vt[10] = '{1'b0, SZ_WORD, 1'b0, 32'(DEPTH*4-4), 32'h0, 32'(DEPTH-1), 1'b0};
        vt[15] = '{1'b0, 2'b11,   1'b0, 32'h44,  32'h0,        32'h00000011, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vt[11] = '{1'b1, SZ_WORD, 1'b0, 32'h42,  32'hCAFEF00D, 32'h0,        1'b1};
        vt[12] = '{1'b0, SZ_WORD, 1'b0, 32'h40,  32'h0,        32'hDEAD55EF, 1'b0};
        vt[13] = '{1'b0, SZ_HALF, 1'b0, 32'h42,  32'h0,        32'hFFFFDEAD, 1'b0};
        vt[14] = '{1'b0, SZ_BYTE, 1'b1, 32'h40,  32'h0,        32'h000000EF, 1'b0};
        vt[16] = '{1'b0, SZ_HALF, 1'b1, 32'h43,  32'h0,        32'h0,        1'b1};
`else
        vt[11] = '{1'b1, SZ_WORD, 1'b0, 32'h42,  32'hCAFEF00D, 32'h0,        1'b0};
        vt[12] = '{1'b0, SZ_WORD, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D, 1'b0};
        vt[13] = '{1'b0, SZ_HALF, 1'b0, 32'h42,  32'h0,        32'hFFFFCAFE, 1'b0};
        vt[14] = '{1'b0, SZ_BYTE, 1'b1, 32'h40,  32'h0,        32'h0000000D, 1'b0};
        vt[16] = '{1'b0, SZ_HALF, 1'b1, 32'h43,  32'h0,        32'h0000CAFE, 1'b0};
`endif

        n_vec           = 0;
        n_miss          = 0;
        bus.ReqValid    = 1'b0;
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = SZ_WORD;
        bus.ReqUnsigned = 1'b0;
        bus.Address     = 32'd0;
        bus.WriteData   = 32'd0;
        rst_n           = 1'b0;

        reset_and_init();

        for (int i = 0; i < 17; i++) begin
            model_access(vt[i].w, vt[i].s, vt[i].u, vt[i].a, vt[i].wd, ed, ee);
            run_req($sformatf("vec%0d", i), vt[i].w, vt[i].s, vt[i].u, vt[i].a, vt[i].wd,
                    vt[i].ed, vt[i].ee);
        end

        // Reset one cycle after a read is accepted: the response must never appear.
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = SZ_WORD;
        bus.ReqUnsigned = 1'b0;
        bus.Address     = 32'h40;
        bus.ReqValid    = 1'b1;
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        seen  = 0;
        rdy   = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.RspValid) seen++;
            if (bus.ReqReady) rdy++;
        end
        check("midrst_rsp_seen", 32'(seen), 32'd0);
        check("midrst_ready_seen", 32'(rdy), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_INIT));
        reset_and_init();
        run_req("post_rst_load", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h00000010, 1'b0);

        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 9))
                0:       a = 32'(DEPTH*4) + 32'($urandom_range(0, 63));
                1, 2, 3: a = 32'($urandom_range(0, 31));
                default: a = 32'($urandom_range(0, DEPTH*4 - 1));
            endcase
            model_access(w, s, u, a, wd, ed, ee);
            run_req($sformatf("rnd%0d", i), w, s, u, a, wd, ed, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data memory for the single-cycle/multicycle datapath. It succeeds the fixed 1024x32 word memory.
- Byte-addressed interface with byte/half/word accesses and sign/zero extension on loads.
- Valid/ready request handshake with configurable read latency.
- Hardware init sweep after reset; range checking with an error response.
- Sits between the load/store logic and the writeback mux.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two, 16..65536)
READ_LAT, 1, cycles from read acceptance to RspValid (1..4)
INIT_MODE, 0, init sweep content: 0 = all zero, 1 = word index (legacy debug pattern)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
ReqValid  in  1  request present
ReqReady  out  1  block can accept a request this cycle
ReqWrite  in  1  1 = store, 0 = load
ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
ReqUnsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
Address  in  32  byte address, little-endian
WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
RspValid  out  1  one-cycle response pulse
ReadData  out  32  extended load data; 0 for stores or on error
RspErr  out  1  access was out of range (or misaligned, see optional feature)
InitDone  out  1  init sweep complete

Behaviour:
- Reset is sampled at posedge Clock; Reset==0 forces the following:
  - state=INIT, sweep counter=0
  - ReqReady=0, RspValid=0, ReadData=0, RspErr=0, InitDone=0
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT:
  - One word written per cycle: mem[cnt] = (INIT_MODE ? cnt : 0).
  - After word DEPTH-1 is written, go to IDLE and set InitDone=1. InitDone stays 1 until the next reset.
- IDLE:
  - ReqReady=1 only in IDLE. A request is accepted when ReqValid && ReqReady at a clock edge.
  - Write: go to RESP.
  - Read: go to RESP if READ_LAT==1; otherwise go to WAIT for READ_LAT-1 cycles, then RESP.
- RESP:
  - RspValid=1 for exactly one cycle, then return to IDLE.
  - No back-to-back acceptance: minimum spacing is READ_LAT+1 cycles for reads and 2 cycles for writes.
- Request fields are registered at acceptance. Input changes after acceptance have no effect.
- Address decode: word index = Address[31:2]; lane = Address[1:0].
- Range check: word index >= DEPTH gives RspErr=1 in RESP, no memory update, ReadData=0.
- Stores update only the addressed lanes, at the acceptance edge (byte enables derived from ReqSize/lane):
  - byte: lane L
  - half: lanes {L, L+1}, with L = Address[1]*2
  - word: all 4 lanes
- Loads: word read at acceptance, then lane-extracted and extended before RESP. ReadData is valid only while RspValid=1 and holds its value otherwise.
- Read after write to the same address (a later request) returns the new data.
- Reset asserted mid-operation: any pending response is dropped (no RspValid) and INIT restarts. Memory contents are overwritten by the sweep.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined:
  - Half access with Address[0]=1, or word access with Address[1:0]!=0, is misaligned.
  - A misaligned access gives RspErr=1, no write, ReadData=0.
- Undefined:
  - Low address bits below the access size are ignored: half uses lane Address[1]*2, word uses lane 0.
  - The access proceeds normally and RspErr reports range errors only.

Decomposition:
- Package data_mem_pkg holds:
  - size encoding constants (SZ_BYTE/SZ_HALF/SZ_WORD)
  - FSM state typedef
  - byte-enable generation and load-extension functions
- One sub-module, data_mem_array:
  - DEPTH x 32 synchronous RAM with 4 byte-write enables
  - single port, registered read
  - keeps the storage inferable as block RAM
- data_mem_ctrl owns the FSM, init sweep, checks and lane logic.

Test Plan:
- Reset low 2 cycles, then high -> InitDone rises exactly DEPTH cycles later. With INIT_MODE=1, a word read at Address 0x10 returns 0x00000004.
- Word store 0xDEADBEEF at 0x40, then word load 0x40 -> RspValid one cycle after store acceptance. Load returns 0xDEADBEEF, RspValid at acceptance+READ_LAT.
- With 0xDEADBEEF stored at 0x40:
  - byte load at 0x43, signed -> 0xFFFFFFDE
  - byte load at 0x43, unsigned -> 0x000000DE
  - half load at 0x40, signed -> 0xFFFFBEEF
- Byte store 0x55 to 0x41 over 0xDEADBEEF, then word load -> 0xDEAD55EF; other lanes unchanged.
- Load at byte address DEPTH*4 -> RspErr=1, ReadData=0. A store there leaves word DEPTH-1 unchanged.
- Read accepted with READ_LAT=3, Reset asserted one cycle later -> no RspValid, ReqReady=0, INIT restarts.
- With DMEM_ALIGN_CHECK_EN, word store to 0x42 -> RspErr=1 and memory unchanged. Without it, the same store writes word 0x40.
